reg_wb_arbiter: RTL and testbench
=================================

# reg_wb_arbiter

Write-port controller for the 32×32 register file. After reset it sequences a clear of every register, then shares the file's single write port between the core writeback path and an auxiliary requester (load return / debug). The core has priority, and a starvation counter guarantees the auxiliary requester forward progress. It sits between the writeback stage and the `reg_file` write inputs (`wren`, `wr`, `wd`).

## Interface
- `NREG`, 32: number of registers cleared at init (must be 2^`AW`).
- `AW`, 5: register address width.
- `DW`, 32: data width.
- `STARVE`, 4: consecutive cycles the aux requester may wait before it is forced through (1..15).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `core_we` in 1: core writeback request.
- `core_wr` in `AW`: core destination register.
- `core_wd` in `DW`: core write data.
- `core_stall` out 1: core must hold `core_we`, `core_wr` and `core_wd` unchanged next cycle.
- `aux_valid` in 1: aux write request.
- `aux_wr` in `AW`: aux destination register.
- `aux_wd` in `DW`: aux write data.
- `aux_ready` out 1: aux request accepted this cycle.
- `init_done` out 1: clear sequence finished; the core may issue.
- `rf_wren` out 1: write enable to the register file.
- `rf_wr` out `AW`: write address to the register file.
- `rf_wd` out `DW`: write data to the register file.

## Operation
- State: `CLEAR` or `RUN`. Registers are `state`, `clr_cnt[AW-1:0]`, `starve_cnt[3:0]` and `init_done`.
- Reset values: `state` = `CLEAR`, `clr_cnt` = 0, `starve_cnt` = 0, `init_done` = 0.
- All other outputs are combinational from the state and inputs.

CLEAR state:
- Drives `rf_wren`=1, `rf_wr`=`clr_cnt`, `rf_wd`=0.
- Holds `aux_ready`=0 and `core_stall`=`core_we`.
- `clr_cnt` increments every cycle.
- When `clr_cnt`==`NREG`-1, the next state is `RUN`, `init_done` goes to 1 and `clr_cnt` goes to 0.

RUN state, grant rules (exactly one source drives the port per cycle):
- If `aux_valid` and `starve_cnt`==`STARVE`: grant aux, and `core_stall`=`core_we`.
- Else if `core_we`: grant core, `aux_ready`=0, `core_stall`=0.
- Else if `aux_valid`: grant aux.
- Else: `rf_wren`=0.

Granted source and port outputs:
- `rf_wr`/`rf_wd` carry the granted source's address and data.
- `aux_ready`=1 whenever aux is granted.

Writes to register 0:
- A grant whose address is 0 drives `rf_wren`=0 (x0 stays zero).
- The handshake still completes: `aux_ready`=1, or the core is not stalled.

Starvation counter:
- Increments on each cycle with `aux_valid` && !`aux_ready`, saturating at `STARVE`.
- Clears to 0 on any cycle with `aux_valid` && `aux_ready`.
- Holds when `aux_valid`=0.

Aux requester contract: once `aux_valid` is raised, `aux_valid`, `aux_wr` and `aux_wd` stay stable until `aux_ready`.

`rf_wd` is don't-care when `rf_wren`=0; drive 0.

## Timing
- Clear: 32 cycles. Edges 1..32 after `rst_n` rises write x0..x31. `init_done` is 1 starting the cycle after edge 32.
- Grant latency is 0 cycles: port outputs follow the inputs in the same cycle, and the register file commits on the next rising edge.
- Worst-case aux wait is `STARVE` cycles, then a grant on cycle `STARVE`+1.
- A forced aux grant stalls the core for exactly 1 cycle; the core is granted on the following cycle unless the aux wait again reaches `STARVE`.
- Simultaneous `core_we` and `aux_valid` with `starve_cnt`<`STARVE`: the core wins and `starve_cnt` increments.
- Requests during `CLEAR`: aux is ignored (`aux_ready`=0, `starve_cnt` held at 0); the core is stalled.
- Asserting `rst_n`=0 mid-clear or mid-run immediately forces:
  - `rf_wren`=0, `init_done`=0, `aux_ready`=0;
  - `core_stall` = `core_we` (CLEAR state).
  - After release, the full clear sequence restarts from x0.

## Test plan
- Reset release with no requests: `rf_wren`=1 for 32 cycles with `rf_wr`=0..31 and `rf_wd`=0, then `init_done`=1 and `rf_wren`=0. Reading any register returns 32'h0.
- RUN, `core_we`=1, `core_wr`=5'h7, `core_wd`=32'h12 → same cycle `rf_wren`=1, `rf_wr`=7, `rf_wd`=32'h12, `core_stall`=0. A read of x7 after the edge returns 32'h12.
- `aux_valid` held with `aux_wr`=2 and `aux_wd`=32'hA5 while `core_we`=1 every cycle, `STARVE`=4:
  - cycles 1-4 grant the core;
  - cycle 5 gives `aux_ready`=1, `rf_wr`=2 and `core_stall`=1;
  - cycle 6 grants the core (held values) and `starve_cnt`=0.
- Aux write to x0 with data 32'hFFFF_FFFF → `aux_ready`=1 and `rf_wren`=0; x0 reads 32'h0.
- `core_we`=1 and `aux_valid`=1 during `CLEAR` → `core_stall`=1 and `aux_ready`=0 until `init_done`. The first RUN cycle grants the core.
- `rst_n` pulsed low at clear cycle 10 and at a RUN cycle:
  - outputs drop asynchronously as listed in Timing;
  - after release, `rf_wr` restarts at 0 and completes 32 clear cycles.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Write-port controller for the 32x32 register file: clears every register after
// reset, then arbitrates the single write port between core writeback and aux.
module reg_wb_arbiter #(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int DW     = 32,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_we,
  input  logic [AW-1:0] core_wr,
  input  logic [DW-1:0] core_wd,
  output logic          core_stall,
  input  logic          aux_valid,
  input  logic [AW-1:0] aux_wr,
  input  logic [DW-1:0] aux_wd,
  output logic          aux_ready,
  output logic          init_done,
  output logic          rf_wren,
  output logic [AW-1:0] rf_wr,
  output logic [DW-1:0] rf_wd
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [3:0]    STARVE_MAX = 4'(STARVE);
  localparam logic [AW-1:0] LAST_REG   = AW'(NREG - 1);

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [3:0]    starve_cnt;
  logic          grant_core;
  logic          grant_aux;
  logic [AW-1:0] sel_wr;
  logic [DW-1:0] sel_wd;

  // A starved aux request beats the core; otherwise the core has priority.
  always_comb begin
    grant_core = 1'b0;
    grant_aux  = 1'b0;
    if (state == RUN) begin
      if (aux_valid && starve_cnt == STARVE_MAX) grant_aux = 1'b1;
      else if (core_we)                          grant_core = 1'b1;
      else if (aux_valid)                        grant_aux = 1'b1;
    end
  end

  always_comb begin
    sel_wr = '0;
    sel_wd = '0;
    if (state == CLEAR) begin
      sel_wr = clr_cnt;
    end else if (grant_aux) begin
      sel_wr = aux_wr;
      sel_wd = aux_wd;
    end else if (grant_core) begin
      sel_wr = core_wr;
      sel_wd = core_wd;
    end
  end

  assign aux_ready  = grant_aux;
  assign core_stall = core_we && !grant_core;
  // rst_n gates the clear write so the port goes quiet the instant reset asserts.
  assign rf_wren    = (state == CLEAR) ? rst_n : ((grant_aux || grant_core) && sel_wr != '0);
  assign rf_wr      = sel_wr;
  assign rf_wd      = rf_wren ? sel_wd : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      starve_cnt <= '0;
      init_done  <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_REG) begin
            state     <= RUN;
            init_done <= 1'b1;
            clr_cnt   <= '0;
          end
        end
        RUN: begin
          if (aux_valid) begin
            if (aux_ready)                     starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: table vectors, hand-written corner
// sequences and randomized traffic checked against a behavioural model.
module tb_reg_wb_arbiter;

  localparam int NREG   = 32;
  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int STARVE = 4;

  logic          clk;
  logic          rst_n;
  logic          core_we;
  logic [AW-1:0] core_wr;
  logic [DW-1:0] core_wd;
  logic          core_stall;
  logic          aux_valid;
  logic [AW-1:0] aux_wr;
  logic [DW-1:0] aux_wd;
  logic          aux_ready;
  logic          init_done;
  logic          rf_wren;
  logic [AW-1:0] rf_wr;
  logic [DW-1:0] rf_wd;

  reg_wb_arbiter #(.NREG(NREG), .AW(AW), .DW(DW), .STARVE(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_we(core_we), .core_wr(core_wr), .core_wd(core_wd), .core_stall(core_stall),
    .aux_valid(aux_valid), .aux_wr(aux_wr), .aux_wd(aux_wd), .aux_ready(aux_ready),
    .init_done(init_done), .rf_wren(rf_wren), .rf_wr(rf_wr), .rf_wd(rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file fed by the DUT's write port.
  logic [DW-1:0] rf_mem [NREG];
  always @(posedge clk) if (rf_wren) rf_mem[rf_wr] <= rf_wd;

  // Reference model: clear progress, aux wait count and expected file contents.
  int            m_clear_idx;
  int            m_starve;
  logic [DW-1:0] m_mem [NREG];
  logic          e_wren, e_stall, e_ready, e_init;
  logic [AW-1:0] e_wr;
  logic [DW-1:0] e_wd;
  logic          last_ready, last_stall;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic          cwe;
    logic [AW-1:0] cwr;
    logic [DW-1:0] cwd;
    logic          av;
    logic [AW-1:0] awr;
    logic [DW-1:0] awd;
    logic          x_wren;
    logic [AW-1:0] x_wr;
    logic [DW-1:0] x_wd;
    logic          x_stall;
    logic          x_ready;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_clear_idx = 0;
    m_starve    = 0;
  endtask

  // Compare DUT outputs against the model for the current cycle, then advance the model.
  task automatic check_output();
    int            src;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    last_ready = aux_ready;
    last_stall = core_stall;
    if (!rst_n) begin
      check("rst_wren", 32'(rf_wren), 32'd0);
      check("rst_init", 32'(init_done), 32'd0);
      check("rst_ready", 32'(aux_ready), 32'd0);
      check("rst_stall", 32'(core_stall), 32'(core_we));
      return;
    end
    if (m_clear_idx < NREG) begin
      e_init = 1'b0; e_wren = 1'b1; e_wr = AW'(m_clear_idx); e_wd = '0;
      e_ready = 1'b0; e_stall = core_we;
    end else begin
      e_init = 1'b1;
      if (aux_valid && m_starve >= STARVE) src = 2;
      else if (core_we)                    src = 1;
      else if (aux_valid)                  src = 2;
      else                                 src = 0;
      addr    = (src == 2) ? aux_wr : (src == 1) ? core_wr : '0;
      data    = (src == 2) ? aux_wd : (src == 1) ? core_wd : '0;
      e_ready = (src == 2);
      e_stall = core_we && (src != 1);
      e_wren  = (src != 0) && (addr != 0);
      e_wr    = addr;
      e_wd    = e_wren ? data : '0;
    end
    check("init_done", 32'(init_done), 32'(e_init));
    check("rf_wren", 32'(rf_wren), 32'(e_wren));
    check("rf_wr", 32'(rf_wr), 32'(e_wr));
    check("rf_wd", rf_wd, e_wd);
    check("aux_ready", 32'(aux_ready), 32'(e_ready));
    check("core_stall", 32'(core_stall), 32'(e_stall));
    if (e_wren) m_mem[e_wr] = e_wd;
    if (m_clear_idx < NREG) begin
      m_clear_idx++;
    end else if (aux_valid) begin
      if (e_ready)              m_starve = 0;
      else if (m_starve < STARVE) m_starve++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_output();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic cwe, input logic [AW-1:0] cwr, input logic [DW-1:0] cwd,
                                input logic av, input logic [AW-1:0] awr, input logic [DW-1:0] awd);
    core_we = cwe; core_wr = cwr; core_wd = cwd;
    aux_valid = av; aux_wr = awr; aux_wd = awd;
  endtask

  task automatic compare_regs(input string tag);
    for (int r = 0; r < NREG; r++) check(tag, rf_mem[r], m_mem[r]);
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any clock edge.
  task automatic async_reset_check();
    rst_n = 1'b0;
    #1;
    check("async_wren", 32'(rf_wren), 32'd0);
    check("async_init", 32'(init_done), 32'd0);
    check("async_ready", 32'(aux_ready), 32'd0);
    check("async_stall", 32'(core_stall), 32'(core_we));
    model_reset();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    last_ready = 1'b0;
    last_stall = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      rf_mem[r] = 32'hDEAD_BEEF;
      m_mem[r]  = 32'hDEAD_BEEF;
    end
    model_reset();
    rst_n = 1'b0;
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
    @(posedge clk); #1;
    step();
    step();

    // Clear sequence with no traffic, then confirm the file is all zero.
    rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) step();
    step();
    compare_regs("clear_regs");

    vecs[0] = '{1'b1, 5'd7,  32'h12,        1'b0, 5'd0, 32'h0,         1'b1, 5'd7,  32'h12,        1'b0, 1'b0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd2, 32'hA5,        1'b1, 5'd2,  32'hA5,        1'b0, 1'b1};
    vecs[3] = '{1'b1, 5'd3,  32'h33,        1'b1, 5'd4, 32'h44,        1'b1, 5'd3,  32'h33,        1'b0, 1'b0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd4, 32'h44,        1'b1, 5'd4,  32'h44,        1'b0, 1'b1};
    vecs[5] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1};
    vecs[6] = '{1'b1, 5'd0,  32'h55,        1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    vecs[7] = '{1'b1, 5'd31, 32'hCAFE_F00D, 1'b0, 5'd0, 32'h0,         1'b1, 5'd31, 32'hCAFE_F00D, 1'b0, 1'b0};

    for (int v = 0; v < 8; v++) begin
      apply_stimulus(vecs[v].cwe, vecs[v].cwr, vecs[v].cwd, vecs[v].av, vecs[v].awr, vecs[v].awd);
      @(negedge clk);
      check($sformatf("vec%0d_wren", v), 32'(rf_wren), 32'(vecs[v].x_wren));
      check($sformatf("vec%0d_wr", v), 32'(rf_wr), 32'(vecs[v].x_wr));
      check($sformatf("vec%0d_wd", v), rf_wd, vecs[v].x_wd);
      check($sformatf("vec%0d_stall", v), 32'(core_stall), 32'(vecs[v].x_stall));
      check($sformatf("vec%0d_ready", v), 32'(aux_ready), 32'(vecs[v].x_ready));
      check_output();
      @(posedge clk); #1;
    end
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    check("x7_read", rf_mem[7], 32'h12);
    check("x0_read", rf_mem[0], 32'h0);

    // Starvation: aux held while the core writes every cycle.
    for (int i = 1; i <= 6; i++) begin
      if (i == 1 || !last_stall) begin
        core_we = 1'b1; core_wr = 5'd9; core_wd = 32'h100 + 32'(i);
      end
      if (i <= 5) begin
        aux_valid = 1'b1; aux_wr = 5'd2; aux_wd = 32'hA5;
      end else begin
        aux_valid = 1'b0;
      end
      @(negedge clk);
      check($sformatf("starve_c%0d_ready", i), 32'(aux_ready), (i == 5) ? 32'd1 : 32'd0);
      check($sformatf("starve_c%0d_stall", i), 32'(core_stall), (i == 5) ? 32'd1 : 32'd0);
      check($sformatf("starve_c%0d_wr", i), 32'(rf_wr), (i == 5) ? 32'd2 : 32'd9);
      if (i == 6) begin
        check("starve_c6_wd", rf_wd, 32'h105);
        check("starve_c6_cnt", 32'(dut.starve_cnt), 32'd0);
      end
      check_output();
      @(posedge clk); #1;
    end

    // Reset mid-clear at cycle 10 with both requesters active throughout.
    apply_stimulus(1'b1, 5'd12, 32'h77, 1'b1, 5'd13, 32'h88);
    async_reset_check();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) step();
    async_reset_check();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) step();
    @(negedge clk);
    check("first_run_wr", 32'(rf_wr), 32'd12);
    check("first_run_stall", 32'(core_stall), 32'd0);
    check("first_run_ready", 32'(aux_ready), 32'd0);
    check_output();
    @(posedge clk); #1;
    core_we = 1'b0;
    step();

    // Reset in RUN while the core is writing.
    apply_stimulus(1'b1, 5'd20, 32'h2020, 1'b0, '0, '0);
    step();
    async_reset_check();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) step();

    // Randomized traffic obeying both requesters' hold contracts.
    for (int i = 0; i < 400; i++) begin
      if (!(core_we && last_stall)) begin
        core_we = ($urandom_range(3) != 0);
        core_wr = AW'($urandom);
        core_wd = $urandom;
      end
      if (!(aux_valid && !last_ready)) begin
        aux_valid = $urandom_range(1);
        aux_wr    = AW'($urandom);
        aux_wd    = $urandom;
      end
      step();
    end
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    compare_regs("final_regs");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
